// File: rtl/dcache_line_xfer_if.sv
// External nibble-wide memory bus used by the data-cache line transfer engine.
// The transfer engine is the master; the memory/controller side is the slave.
interface dcache_line_xfer_if;
   logic       mem_sel;
   logic       mem_oe;
   logic [3:0] mem_dout;
   logic [3:0] mem_din;
   logic       mem_ready;

   modport master (
      output mem_sel,
      output mem_oe,
      output mem_dout,
      input  mem_din,
      input  mem_ready
   );

   modport slave (
      input  mem_sel,
      input  mem_oe,
      input  mem_dout,
      output mem_din,
      output mem_ready
   );
endinterface

// File: rtl/dcache_line_xfer.sv
// Moves one cache line between the data cache and a nibble-serial memory bus:
// command nibble, line address (MSB nibble first), optional turnaround, then data.
module dcache_line_xfer #(
   parameter  int LINE_LENGTH = 4,
   parameter  int PA          = 22,
   localparam int TW          = PA - $clog2(LINE_LENGTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          op_write,
   input  logic [TW-1:0] line_addr,
   output logic          busy,
   output logic          done,
   output logic [3:0]    dread,
   output logic          wstrobe_d,
   input  logic [3:0]    dwrite,
   output logic          rstrobe_d,
   dcache_line_xfer_if.master mem
);
   localparam int NIB = 2 * LINE_LENGTH;
   localparam int NA  = (TW + 3) / 4;
   localparam int AW  = 4 * NA;
   localparam int CW  = $clog2(NIB);
   localparam int ACW = (NA > 1) ? $clog2(NA) : 1;
   localparam logic [CW-1:0]  LAST_NIB  = CW'(NIB - 1);
   localparam logic [ACW-1:0] LAST_ADDR = ACW'(NA - 1);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, TURN, DATA, DONE} state_t;

   state_t         state;
   logic           op_q;
   logic [AW-1:0]  addr_sh;
   logic [ACW-1:0] addr_cnt;
   logic [CW-1:0]  nib_cnt;
   logic           sel_q;
   logic           oe_q;
   logic           done_q;
   logic           busy_q;
   logic [3:0]     dout_q;
   logic           in_data;

   // Outputs for the next state are computed alongside the transition so every
   // bus control signal comes straight from a flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         op_q     <= 1'b0;
         addr_sh  <= '0;
         addr_cnt <= '0;
         nib_cnt  <= '0;
         sel_q    <= 1'b0;
         oe_q     <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         dout_q   <= 4'h0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_q    <= op_write;
                  addr_sh <= AW'(line_addr);
                  busy_q  <= 1'b1;
                  sel_q   <= 1'b1;
                  oe_q    <= 1'b1;
                  dout_q  <= op_write ? 4'h2 : 4'h3;
                  state   <= CMD;
               end
            end
            CMD: begin
               dout_q   <= addr_sh[AW-1 -: 4];
               addr_sh  <= addr_sh << 4;
               addr_cnt <= '0;
               state    <= ADDR;
            end
            ADDR: begin
               if (addr_cnt == LAST_ADDR) begin
                  dout_q  <= 4'h0;
                  nib_cnt <= '0;
                  if (op_q) begin
                     state <= DATA;
                  end else begin
                     oe_q  <= 1'b0;
                     state <= TURN;
                  end
               end else begin
                  addr_cnt <= addr_cnt + 1'b1;
                  dout_q   <= addr_sh[AW-1 -: 4];
                  addr_sh  <= addr_sh << 4;
               end
            end
            TURN: begin
               nib_cnt <= '0;
               state   <= DATA;
            end
            // A low mem_ready is a wait state: nothing moves until memory is ready.
            DATA: begin
               if (mem.mem_ready) begin
                  if (nib_cnt == LAST_NIB) begin
                     nib_cnt <= '0;
                     done_q  <= 1'b1;
                     sel_q   <= 1'b0;
                     oe_q    <= 1'b0;
                     state   <= DONE;
                  end else begin
                     nib_cnt <= nib_cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Data nibbles pass straight through between cache and bus during DATA.
   assign in_data      = (state == DATA);
   assign mem.mem_sel  = sel_q;
   assign mem.mem_oe   = oe_q;
   assign mem.mem_dout = (in_data && op_q) ? dwrite : dout_q;
   assign dread        = (in_data && !op_q) ? mem.mem_din : 4'h0;
   assign wstrobe_d    = in_data && !op_q && mem.mem_ready;
   assign rstrobe_d    = in_data && op_q && mem.mem_ready;
   assign busy         = busy_q;
   assign done         = done_q;
endmodule
